// File: rtl/ldpc_address_generator.sv
// Circular address counter for the LDPC memory-access path: starts at the
// circulant shift COUNT_FROM, wraps through DEPTH addresses, flags the final one.
module ldpc_address_generator #(
  parameter int DATA_WIDTH = 8,
  parameter int COUNT_FROM = 12,
  parameter int DEPTH      = 2 ** DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  last,
  output logic                  wrapped
);

  // Compare one bit wider than the address so DEPTH == 2**DATA_WIDTH still fits.
  localparam logic [DATA_WIDTH:0]   WRAP_AT    = (DATA_WIDTH + 1)'(DEPTH - 1);
  localparam logic [DATA_WIDTH:0]   FINAL_ADDR = (COUNT_FROM == 0) ? WRAP_AT
                                                 : (DATA_WIDTH + 1)'(COUNT_FROM - 1);
  localparam logic [DATA_WIDTH-1:0] START_ADDR = DATA_WIDTH'(COUNT_FROM);

  if (DEPTH < 2) begin : g_depth_small
    $fatal(1, "ldpc_address_generator: DEPTH=%0d must be at least 2", DEPTH);
  end
  if (longint'(DEPTH) > (longint'(1) << DATA_WIDTH)) begin : g_depth_large
    $fatal(1, "ldpc_address_generator: DEPTH=%0d exceeds 2**DATA_WIDTH", DEPTH);
  end
  if (COUNT_FROM < 0 || COUNT_FROM >= DEPTH) begin : g_start_range
    $fatal(1, "ldpc_address_generator: COUNT_FROM=%0d outside 0..DEPTH-1", COUNT_FROM);
  end

  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  wrapped_q, wrapped_d;
  logic                  at_wrap;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    out_d     = out_q;
    wrapped_d = 1'b0;
    at_wrap   = ({1'b0, out_q} == WRAP_AT);
    if (en) begin
      if (at_wrap) begin
        out_d     = '0;
        wrapped_d = 1'b1;
      end else begin
        out_d     = out_q + DATA_WIDTH'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q     <= START_ADDR;
      wrapped_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign out     = out_q;
  assign wrapped = wrapped_q;
  assign last    = ({1'b0, out_q} == FINAL_ADDR);

endmodule

// File: tb/tb_ldpc_address_generator.sv
// Directed bench for ldpc_address_generator: four parameterisations driven
// from one linear sequence, sampled on the falling clock edge.
module tb_ldpc_address_generator;

  logic clk;
  int   checks;
  int   errors;

  logic       reset_a, en_a, last_a, wrapped_a;
  logic [7:0] out_a;
  logic       reset_b, en_b, last_b, wrapped_b;
  logic [3:0] out_b;
  logic       reset_c, en_c, last_c, wrapped_c;
  logic [2:0] out_c;
  logic       reset_d, en_d, last_d, wrapped_d;
  logic [7:0] out_d;

  ldpc_address_generator #(.DATA_WIDTH(8), .COUNT_FROM(12), .DEPTH(256)) dut_a (
    .clk(clk), .reset(reset_a), .en(en_a), .out(out_a), .last(last_a), .wrapped(wrapped_a));
  ldpc_address_generator #(.DATA_WIDTH(4), .COUNT_FROM(12), .DEPTH(16)) dut_b (
    .clk(clk), .reset(reset_b), .en(en_b), .out(out_b), .last(last_b), .wrapped(wrapped_b));
  ldpc_address_generator #(.DATA_WIDTH(3), .COUNT_FROM(0), .DEPTH(8)) dut_c (
    .clk(clk), .reset(reset_c), .en(en_c), .out(out_c), .last(last_c), .wrapped(wrapped_c));
  ldpc_address_generator #(.DATA_WIDTH(8), .COUNT_FROM(250), .DEPTH(256)) dut_d (
    .clk(clk), .reset(reset_d), .en(en_d), .out(out_d), .last(last_d), .wrapped(wrapped_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    int exp_b;
    int exp_d;
    checks = 0;
    errors = 0;
    {reset_a, reset_b, reset_c, reset_d} = 4'b1111;
    {en_a, en_b, en_c, en_d} = 4'b0000;
    #2;
    {reset_a, reset_b, reset_c, reset_d} = 4'b0000;
    #1;
    // Reset values appear without any clock edge.
    check("a_rst_out", 32'(out_a), 12);
    check("b_rst_out", 32'(out_b), 12);
    check("c_rst_out", 32'(out_c), 0);
    check("d_rst_out", 32'(out_d), 250);

    // Defaults 8/12/256: held in reset for a cycle, then counting from 13.
    @(negedge clk);
    check("a_hold_rst_out", 32'(out_a), 12);
    check("a_hold_rst_last", 32'(last_a), 0);
    check("a_hold_rst_wrapped", 32'(wrapped_a), 0);
    en_a = 1'b1;
    reset_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("a_count_out", 32'(out_a), 32'(13 + i));
      check("a_count_last", 32'(last_a), 0);
      check("a_count_wrapped", 32'(wrapped_a), 0);
    end
    en_a = 1'b0;

    // DEPTH=16, COUNT_FROM=12: rotation through 15 -> 0 and the final address 11.
    check("b_pre_last", 32'(last_b), 0);
    en_b = 1'b1;
    reset_b = 1'b1;
    exp_b = 12;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      exp_b = (exp_b + 1) % 16;
      check("b_seq_out", 32'(out_b), 32'(exp_b));
      check("b_seq_wrapped", 32'(wrapped_b), (exp_b == 0) ? 32'd1 : 32'd0);
      check("b_seq_last", 32'(last_b), (exp_b == 11) ? 32'd1 : 32'd0);
    end
    check("b_at_14", 32'(out_b), 14);

    // Hold with en=0 for three edges at 14.
    en_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b_hold_out", 32'(out_b), 14);
      check("b_hold_wrapped", 32'(wrapped_b), 0);
    end
    en_b = 1'b1;
    @(negedge clk);
    check("b_resume_out", 32'(out_b), 15);
    check("b_resume_wrapped", 32'(wrapped_b), 0);
    @(negedge clk);
    check("b_resume_wrap_out", 32'(out_b), 0);
    check("b_resume_wrap_pulse", 32'(wrapped_b), 1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("b_to5_out", 32'(out_b), 32'(i));
    end

    // Asynchronous reset between edges while out=5.
    #2;
    reset_b = 1'b0;
    #1;
    check("b_async_rst_out", 32'(out_b), 12);
    check("b_async_rst_wrapped", 32'(wrapped_b), 0);
    @(negedge clk);
    check("b_rst_held_out", 32'(out_b), 12);
    reset_b = 1'b1;
    en_b = 1'b0;

    // COUNT_FROM=0, DEPTH=8: plain 0..7 with last at 7, wrap on the second 0.
    check("c_rst_last", 32'(last_c), 0);
    en_c = 1'b1;
    reset_c = 1'b1;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      check("c_seq_out", 32'(out_c), 32'(i % 8));
      check("c_seq_last", 32'(last_c), (i == 7) ? 32'd1 : 32'd0);
      check("c_seq_wrapped", 32'(wrapped_c), (i == 8) ? 32'd1 : 32'd0);
    end
    en_c = 1'b0;

    // DEPTH=256, COUNT_FROM=250: full-width wrap 255 -> 0, last at 249.
    check("d_rst_last", 32'(last_d), 0);
    en_d = 1'b1;
    reset_d = 1'b1;
    exp_d = 250;
    for (int i = 0; i < 262; i++) begin
      @(negedge clk);
      exp_d = (exp_d + 1) % 256;
      check("d_seq_out", 32'(out_d), 32'(exp_d));
      check("d_seq_wrapped", 32'(wrapped_d), (exp_d == 0) ? 32'd1 : 32'd0);
      check("d_seq_last", 32'(last_d), (exp_d == 249) ? 32'd1 : 32'd0);
    end
    check("d_second_wrap_out", 32'(out_d), 0);
    check("d_second_wrap_pulse", 32'(wrapped_d), 1);

    // Asynchronous reset while the wrap pulse is high clears it at once.
    #2;
    reset_d = 1'b0;
    #1;
    check("d_async_rst_out", 32'(out_d), 250);
    check("d_async_rst_wrapped", 32'(wrapped_d), 0);
    check("d_async_rst_last", 32'(last_d), 0);
    reset_d = 1'b1;
    en_d = 1'b0;

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldpc_address_generator.md
Name:
ldpc_address_generator

Overview:
Circular address counter for the LDPC decoder's memory-access path. It produces one memory address per enabled clock cycle. The sequence starts at a programmable offset (the circulant shift), wraps through the full address depth, and ends at the address just before the offset. A decoder controller consumes `out` as a read/write address and uses `last` to detect completion of one full pass.

Parameters:
- DATA_WIDTH, 8, width of the address output in bits.
- COUNT_FROM, 12, start address (shift offset) loaded on reset; legal range 0..DEPTH-1.
- DEPTH, 2**DATA_WIDTH, number of addresses in one pass; legal range 2..2**DATA_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable; the address advances on a clock edge only when en=1.
- out  output  DATA_WIDTH  current address (registered).
- last  output  1  high while `out` holds the final address of the pass.
- wrapped  output  1  one-cycle registered pulse, high in the cycle after `out` rolls from DEPTH-1 to 0.

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - out = COUNT_FROM.
  - wrapped = 0.
  - last is re-evaluated combinationally from out.
  - All three hold while reset stays low.
- Reset release takes effect at the first rising clk edge after reset goes high. If en=1 at that edge, out advances to COUNT_FROM+1 (modulo DEPTH).
- Count step, on a rising edge with reset=1 and en=1:
  - If out == DEPTH-1, then out <= 0 and wrapped <= 1.
  - Otherwise out <= out+1 and wrapped <= 0.
- Hold, on a rising edge with en=0: out holds its value and wrapped <= 0.
- Sequence length: exactly DEPTH enabled cycles per pass: COUNT_FROM, COUNT_FROM+1, ..., DEPTH-1, 0, ..., COUNT_FROM-1. The sequence then repeats indefinitely, starting again at COUNT_FROM; no stop or done state.
- last (combinational):
  - last = (out == COUNT_FROM-1) when COUNT_FROM > 0.
  - last = (out == DEPTH-1) when COUNT_FROM == 0.
  - last is independent of en.
- Arithmetic:
  - The comparison against DEPTH-1 is done at DATA_WIDTH+1 bits, so DEPTH = 2**DATA_WIDTH wraps correctly.
  - out never takes a value >= DEPTH.
- COUNT_FROM == 0: no rotation; the sequence is 0..DEPTH-1. wrapped and the start of the next pass coincide.
- Reset mid-pass: out returns to COUNT_FROM immediately (asynchronously), with no clock needed, and wrapped clears.
- Illegal parameters (COUNT_FROM >= DEPTH, DEPTH > 2**DATA_WIDTH, or DEPTH < 2) are rejected at elaboration with a fatal error.
- Latency: out changes one clock after the enabled edge. There is no pipeline beyond the output register.

Test Plan:
- Defaults (8/12/256), hold reset=0 for 1 cycle, en=1, release reset. Required: out = 12 during reset, then 13, 14, 15, ... on successive edges; last=0 and wrapped=0 throughout 10 cycles.
- DEPTH=16, COUNT_FROM=12, en=1 for 20 cycles. Required out sequence: 12, 13, 14, 15, 0, 1, ..., 11, 12, ...; wrapped=1 exactly in the cycle out=0; last=1 exactly when out=11.
- Toggle en=0 for 3 cycles while out=14 (DEPTH=16). Required: out stays 14 and wrapped stays 0; counting resumes at 15 when en returns to 1.
- Assert reset asynchronously between clock edges while out=5 (DEPTH=16, COUNT_FROM=12). Required: out = 12 before the next edge, and wrapped = 0.
- COUNT_FROM=0, DEPTH=8, en=1 for 10 cycles. Required: out = 0..7, 0, 1; last=1 at out=7; wrapped=1 at the second occurrence of out=0.
- DEPTH=256, COUNT_FROM=250, en=1. Required: out 255 -> 0 with wrapped=1, never out=256 or an out-of-range value, and last=1 at out=249.
